// File: rtl/niosperisys_pio_in_irq.sv
// Avalon-MM input PIO slave: synchroniser, per-bit debounce, sticky edge capture
// and a masked level interrupt for switch/button inputs.
module niosperisys_pio_in_irq #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] edge_set, w1c;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;

  // Metastability chain; stage 0 takes the raw pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign deb_d = sync_out;
    end else begin : g_debounce
      localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

      // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching clocks
      always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
          if (sync_out[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              deb_d[i] = sync_out[i];
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // Edge selection, bus decode and next-state for the software-visible registers
  always_comb begin
    edge_set   = '0;
    readdata_d = '0;
    wr_en      = chipselect & ~write_n;
    w1c        = '0;
    mask_d     = mask_q;

    case (EDGE_TYPE)
      0:       edge_set = deb_d & ~deb_q;
      1:       edge_set = ~deb_d & deb_q;
      default: edge_set = deb_d ^ deb_q;
    endcase

    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE)) begin
      w1c = writedata[WIDTH-1:0];
    end
    // A new edge overrides a simultaneous clear
    edge_cap_d = (edge_cap_q & ~w1c) | edge_set;

    case (address)
      ADDR_DATA: readdata_d = 32'(deb_q);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_EDGE: readdata_d = 32'(edge_cap_q);
      default:   readdata_d = '0;
    endcase

    // Captured edges reach irq in the clock they occur; mask changes one clock later
    irq_d = |(edge_cap_d & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q      <= '0;
      mask_q     <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      deb_q      <= deb_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_niosperisys_pio_in_irq.sv
// Directed bench for niosperisys_pio_in_irq across default, debounced,
// falling-edge and 32-bit any-edge configurations sharing one bus.
module tb_niosperisys_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in32;
  logic [7:0]  in8;

  logic [31:0] rd_a, rd_b, rd_c, rd_d;
  logic        irq_a, irq_b, irq_c, irq_d;

  int checks = 0;
  int errors = 0;

  assign in8 = in32[7:0];

  always #5 clk = ~clk;

  niosperisys_pio_in_irq u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in8),
    .readdata(rd_a), .irq(irq_a)
  );

  niosperisys_pio_in_irq #(.DEBOUNCE_CYCLES(4)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in8),
    .readdata(rd_b), .irq(irq_b)
  );

  niosperisys_pio_in_irq #(.EDGE_TYPE(1)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in8),
    .readdata(rd_c), .irq(irq_c)
  );

  niosperisys_pio_in_irq #(.WIDTH(32), .EDGE_TYPE(2)) u_d (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in32),
    .readdata(rd_d), .irq(irq_d)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in32       = 32'h0000_00A5;
    repeat (3) tick();
    check("reset_rd_a", rd_a, 32'h0);
    check("reset_irq_a", 32'(irq_a), 32'h0);
    check("reset_rd_d", rd_d, 32'h0);

    // Reset release with pins already high
    reset_n = 1'b1;
    repeat (3) tick();
    check("rel_rd_a_e3", rd_a, 32'h0);
    tick();
    check("rel_rd_a_e4", rd_a, 32'h0000_00A5);
    check("rel_rd_d_e4", rd_d, 32'h0000_00A5);
    rd(2'd3);
    check("rel_edge_a", rd_a, 32'h0000_00A5);
    check("rel_edge_c", rd_c, 32'h0);
    check("rel_edge_d", rd_d, 32'h0000_00A5);
    repeat (3) tick();
    rd(2'd0);
    check("rel_rd_b", rd_b, 32'h0000_00A5);
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick();

    // Edge to irq latency and W1C
    in32 = 32'h0000_00A4;
    repeat (8) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h1);
    in32 = 32'h0000_00A5;
    tick();
    tick();
    check("irq_early", 32'(irq_a), 32'h0);
    tick();
    check("irq_rise", 32'(irq_a), 32'h1);
    bus_write(2'd3, 32'h1);
    check("irq_w1c", 32'(irq_a), 32'h0);

    // Masking
    bus_write(2'd2, 32'h0);
    in32 = 32'h0000_00AD;
    repeat (5) tick();
    rd(2'd3);
    check("mask_edge_a", rd_a, 32'h0000_0008);
    check("mask_irq_off", 32'(irq_a), 32'h0);
    bus_write(2'd2, 32'h8);
    check("mask_irq_wr", 32'(irq_a), 32'h0);
    tick();
    check("mask_irq_on", 32'(irq_a), 32'h1);

    // Debounce: 3-clock glitch rejected, 6-clock pulse accepted
    repeat (8) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd0;
    tick();
    in32 = 32'h0000_00AF;
    repeat (3) tick();
    in32 = 32'h0000_00AD;
    repeat (8) tick();
    check("deb_glitch_data", rd_b, 32'h0000_00AD);
    rd(2'd3);
    check("deb_glitch_edge", rd_b, 32'h0);
    rd(2'd0);
    in32 = 32'h0000_00AF;
    repeat (6) tick();
    check("deb_e6", rd_b, 32'h0000_00AD);
    in32 = 32'h0000_00AD;
    tick();
    check("deb_e7", rd_b, 32'h0000_00AF);
    rd(2'd3);
    check("deb_edge", rd_b, 32'h0000_0002);

    // Edge and W1C in the same clock: edge wins
    repeat (8) tick();
    in32 = 32'h0000_00A9;
    repeat (8) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick();
    in32 = 32'h0000_00AD;
    tick();
    tick();
    bus_write(2'd3, 32'h4);
    rd(2'd3);
    check("race_edge_a", rd_a, 32'h0000_0004);

    // Falling and any-edge configurations
    repeat (8) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick();
    in32 = 32'h0000_00A9;
    repeat (8) tick();
    rd(2'd3);
    check("fall_edge_c", rd_c, 32'h0000_0004);
    check("fall_edge_d", rd_d, 32'h0000_0004);
    check("fall_edge_a", rd_a, 32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    tick();
    in32 = 32'h0000_00AD;
    repeat (8) tick();
    rd(2'd3);
    check("rise_edge_c", rd_c, 32'h0);
    check("rise_edge_d", rd_d, 32'h0000_0004);
    check("rise_edge_a", rd_a, 32'h0000_0004);
    rd(2'd1);
    check("rsvd_a", rd_a, 32'h0);
    check("rsvd_c", rd_c, 32'h0);
    check("rsvd_d", rd_d, 32'h0);

    // Full 32-bit data word
    in32 = 32'hDEAD_BEAD;
    repeat (5) tick();
    rd(2'd0);
    check("wide_data_d", rd_d, 32'hDEAD_BEAD);
    check("narrow_data_a", rd_a, 32'h0000_00AD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
